if_fetch_unit: RTL

Instruction-fetch stage for the cached TSC pipeline. It holds the fetch PC and a direct-mapped instruction cache. On a miss it refills one line from the DMA memory port. It drives IF_data_ready, which the downstream hazard detector consumes, and it applies the branch and jump redirects that the hazard detector raises.

---
 rtl/if_fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC plus a direct-mapped, read-only instruction
// cache that refills one line at a time from the memory port on a miss.
module if_fetch_unit #(
  parameter int unsigned          WORD_SIZE  = 16,
  parameter int unsigned          LINE_WORDS = 4,
  parameter int unsigned          NUM_LINES  = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             branch_failed,
  input  logic [WORD_SIZE-1:0]             branch_pc,
  input  logic                             jump_failed,
  input  logic [WORD_SIZE-1:0]             jump_pc,
  output logic [WORD_SIZE-1:0]             IF_PC,
  output logic [WORD_SIZE-1:0]             IF_inst,
  output logic                             IF_data_ready,
  output logic                             i_readM,
  output logic [WORD_SIZE-1:0]             i_address,
  input  logic [LINE_WORDS*WORD_SIZE-1:0]  i_data,
  input  logic                             i_mem_ready,
  output logic [WORD_SIZE-1:0]             hit_count,
  output logic [WORD_SIZE-1:0]             miss_count
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = WORD_SIZE - OFF_W - IDX_W;

  localparam logic [0:0] S_LOOKUP = 1'b0;
  localparam logic [0:0] S_MISS   = 1'b1;

  logic [0:0]                            r_state;
  logic [0:0]                            w_state_nxt;
  logic [WORD_SIZE-1:0]                  r_pc;
  logic [WORD_SIZE-1:0]                  w_pc_nxt;
  logic [WORD_SIZE-1:0]                  r_miss_addr;
  logic [WORD_SIZE-1:0]                  r_hit_cnt;
  logic [WORD_SIZE-1:0]                  r_miss_cnt;
  logic [NUM_LINES-1:0]                  r_valid;
  logic [TAG_W-1:0]                      r_tag  [NUM_LINES];
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0]  r_data [NUM_LINES];

  logic [OFF_W-1:0]     w_off;
  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [IDX_W-1:0]     w_fill_idx;
  logic [TAG_W-1:0]     w_fill_tag;
  logic [WORD_SIZE-1:0] w_line_addr;
  logic                 w_hit;
  logic                 w_ready;
  logic                 w_redirect;
  logic                 w_miss_start;
  logic                 w_fill;
  logic                 w_hit_acc;

  assign w_off       = r_pc[OFF_W-1:0];
  assign w_idx       = r_pc[OFF_W +: IDX_W];
  assign w_tag       = r_pc[WORD_SIZE-1 -: TAG_W];
  assign w_fill_idx  = r_miss_addr[OFF_W +: IDX_W];
  assign w_fill_tag  = r_miss_addr[WORD_SIZE-1 -: TAG_W];
  assign w_line_addr = {r_pc[WORD_SIZE-1:OFF_W], OFF_W'(0)};
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ready     = (r_state == S_LOOKUP) && w_hit;
  assign w_redirect  = branch_failed || jump_failed;

  // Next-state, next-PC and event strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_miss_start = 1'b0;
    w_fill       = 1'b0;
    w_hit_acc    = 1'b0;
    case (r_state)
      S_LOOKUP: begin
        if (!w_hit && !w_redirect) begin
          w_state_nxt  = S_MISS;
          w_miss_start = 1'b1;
        end
      end
      S_MISS: begin
        if (i_mem_ready) begin
          w_state_nxt = S_LOOKUP;
          w_fill      = 1'b1;
        end
      end
      default: w_state_nxt = S_LOOKUP;
    endcase
    // The older instruction (EX branch) outranks the younger ID jump
    if (branch_failed) begin
      w_pc_nxt = branch_pc;
    end else if (jump_failed) begin
      w_pc_nxt = jump_pc;
    end else if (w_ready && !stall) begin
      w_pc_nxt = r_pc + WORD_SIZE'(1);
    end
    w_hit_acc = w_ready && !stall && !w_redirect;
  end

  // Control state, PC, valid bits and saturating counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_LOOKUP;
      r_pc        <= RESET_PC;
      r_miss_addr <= '0;
      r_valid     <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_miss_start) begin
        r_miss_addr <= w_line_addr;
      end
      if (w_fill) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
      if (w_hit_acc && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + WORD_SIZE'(1);
      end
      if (w_miss_start && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + WORD_SIZE'(1);
      end
    end
  end

  // Tag and data arrays need no reset; valid bits gate every use
  always_ff @(posedge clk) begin
    if (w_fill && !reset) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= i_data;
    end
  end

  assign IF_PC         = r_pc;
  assign IF_data_ready = w_ready;
  assign IF_inst       = w_ready ? r_data[w_idx][w_off] : '0;
  assign i_readM       = (r_state == S_MISS);
  assign i_address     = (r_state == S_MISS) ? r_miss_addr : w_line_addr;
  assign hit_count     = r_hit_cnt;
  assign miss_count    = r_miss_cnt;

endmodule
